// File: rtl/axi_rd_arbiter.sv
// AXI read-channel interconnect core: two masters (M0 fetch, M1 data)
// round-robin arbitrated onto six decoded slaves plus an internal
// default slave that answers address misses with DECERR beats.
// One read transaction is in flight at a time.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate masters, accept one AR, capture payload and target
// ADDR  | present AR to the decoded slave until it accepts
// DATA  | route R beats from the slave to the granted master
// DEF   | default slave returns ARLEN+1 DECERR beats to granted master
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
) (
    input  logic                AXI_CLK_i,
    input  logic                AXI_RST_i,

    input  logic [ID_W-1:0]     ARID_M0_i,
    input  logic [ADDR_W-1:0]   ARADDR_M0_i,
    input  logic [LEN_W-1:0]    ARLEN_M0_i,
    input  logic [SIZE_W-1:0]   ARSIZE_M0_i,
    input  logic [1:0]          ARBURST_M0_i,
    input  logic                ARVALID_M0_i,
    output logic                ARREADY_M0_o,
    output logic [ID_W-1:0]     RID_M0_o,
    output logic [DATA_W-1:0]   RDATA_M0_o,
    output logic [1:0]          RRESP_M0_o,
    output logic                RLAST_M0_o,
    output logic                RVALID_M0_o,
    input  logic                RREADY_M0_i,

    input  logic [ID_W-1:0]     ARID_M1_i,
    input  logic [ADDR_W-1:0]   ARADDR_M1_i,
    input  logic [LEN_W-1:0]    ARLEN_M1_i,
    input  logic [SIZE_W-1:0]   ARSIZE_M1_i,
    input  logic [1:0]          ARBURST_M1_i,
    input  logic                ARVALID_M1_i,
    output logic                ARREADY_M1_o,
    output logic [ID_W-1:0]     RID_M1_o,
    output logic [DATA_W-1:0]   RDATA_M1_o,
    output logic [1:0]          RRESP_M1_o,
    output logic                RLAST_M1_o,
    output logic                RVALID_M1_o,
    input  logic                RREADY_M1_i,

    output logic [IDS_W-1:0]    ARID_S_o,
    output logic [ADDR_W-1:0]   ARADDR_S_o,
    output logic [LEN_W-1:0]    ARLEN_S_o,
    output logic [SIZE_W-1:0]   ARSIZE_S_o,
    output logic [1:0]          ARBURST_S_o,
    output logic [5:0]          ARVALID_S_o,
    input  logic [5:0]          ARREADY_S_i,
    input  logic [6*IDS_W-1:0]  RID_S_i,
    input  logic [6*DATA_W-1:0] RDATA_S_i,
    input  logic [11:0]         RRESP_S_i,
    input  logic [5:0]          RLAST_S_i,
    input  logic [5:0]          RVALID_S_i,
    output logic [5:0]          RREADY_S_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DEF  = 2'd3;

    localparam logic [2:0] TGT_DEF = 3'd6;
    localparam int         TAG_W   = IDS_W - ID_W;

    logic [1:0]        state;
    logic              last_grant;
    logic              grant;
    logic [2:0]        target;
    logic [IDS_W-1:0]  ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic [SIZE_W-1:0] ar_size;
    logic [1:0]        ar_burst;
    logic [LEN_W-1:0]  beat_cnt;

    logic              pick;
    logic              grant_now;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;
    logic [SIZE_W-1:0] sel_size;
    logic [1:0]        sel_burst;
    logic [2:0]        sel_tgt;

    logic              s_rvalid;
    logic              s_rlast;
    logic [IDS_W-1:0]  s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_arready;
    logic              m_rready;

    logic              r_valid;
    logic              r_last;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    logic              unused_rid_hi;

    function automatic logic [2:0] decode(input logic [ADDR_W-1:0] a);
        logic [2:0] t;
        t = TGT_DEF;
        if (a <= ADDR_W'(32'h0000_3FFF))
            t = 3'd0;
        else if (a >= ADDR_W'(32'h0001_0000) && a <= ADDR_W'(32'h0001_FFFF))
            t = 3'd1;
        else if (a >= ADDR_W'(32'h0002_0000) && a <= ADDR_W'(32'h0002_FFFF))
            t = 3'd2;
        else if (a >= ADDR_W'(32'h1000_0000) && a <= ADDR_W'(32'h1000_03FF))
            t = 3'd3;
        else if (a >= ADDR_W'(32'h1001_0000) && a <= ADDR_W'(32'h1001_03FF))
            t = 3'd4;
        else if (a >= ADDR_W'(32'h2000_0000) && a <= ADDR_W'(32'h201F_FFFF))
            t = 3'd5;
        return t;
    endfunction

    // Round-robin pick: on a tie the master not granted last wins.
    always_comb begin
        pick = 1'b0;
        if (ARVALID_M0_i && ARVALID_M1_i)
            pick = ~last_grant;
        else if (ARVALID_M1_i)
            pick = 1'b1;
    end

    // Reset gating keeps ARREADY low while reset is held even though IDLE is combinational.
    assign grant_now = (state == ST_IDLE) && (ARVALID_M0_i || ARVALID_M1_i) && AXI_RST_i;

    assign sel_id    = pick ? ARID_M1_i    : ARID_M0_i;
    assign sel_addr  = pick ? ARADDR_M1_i  : ARADDR_M0_i;
    assign sel_len   = pick ? ARLEN_M1_i   : ARLEN_M0_i;
    assign sel_size  = pick ? ARSIZE_M1_i  : ARSIZE_M0_i;
    assign sel_burst = pick ? ARBURST_M1_i : ARBURST_M0_i;
    assign sel_tgt   = decode(sel_addr);

    // Select the targeted slave's handshake and R payload.
    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_rid     = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        for (int n = 0; n < 6; n++) begin
            if (target == 3'(n)) begin
                s_arready = ARREADY_S_i[n];
                s_rvalid  = RVALID_S_i[n];
                s_rlast   = RLAST_S_i[n];
                s_rid     = RID_S_i[n*IDS_W +: IDS_W];
                s_rdata   = RDATA_S_i[n*DATA_W +: DATA_W];
                s_rresp   = RRESP_S_i[n*2 +: 2];
            end
        end
    end

    assign m_rready      = grant ? RREADY_M1_i : RREADY_M0_i;
    assign unused_rid_hi = ^s_rid[IDS_W-1:ID_W];

    // Transaction sequencing: grant/capture, AR handshake, R drain, default-slave beats.
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            target     <= 3'd0;
            ar_id      <= '0;
            ar_addr    <= '0;
            ar_len     <= '0;
            ar_size    <= '0;
            ar_burst   <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        grant      <= pick;
                        last_grant <= pick;
                        target     <= sel_tgt;
                        ar_id      <= {TAG_W'(pick), sel_id};
                        ar_addr    <= sel_addr;
                        ar_len     <= sel_len;
                        ar_size    <= sel_size;
                        ar_burst   <= sel_burst;
                        beat_cnt   <= '0;
                        state      <= (sel_tgt == TGT_DEF) ? ST_DEF : ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (s_arready)
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (s_rvalid && m_rready && s_rlast)
                        state <= ST_IDLE;
                end
                default: begin
                    if (m_rready) begin
                        if (beat_cnt == ar_len) begin
                            beat_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // R beat source: routed slave in DATA, internal DECERR generator in DEF.
    always_comb begin
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_id    = '0;
        r_data  = '0;
        r_resp  = '0;
        if (state == ST_DATA) begin
            r_valid = s_rvalid;
            r_last  = s_rlast;
            r_id    = s_rid[ID_W-1:0];
            r_data  = s_rdata;
            r_resp  = s_rresp;
        end else if (state == ST_DEF) begin
            r_valid = 1'b1;
            r_last  = (beat_cnt == ar_len);
            r_id    = ar_id[ID_W-1:0];
            r_resp  = 2'b11;
        end
    end

    assign ARREADY_M0_o = grant_now & ~pick;
    assign ARREADY_M1_o = grant_now & pick;

    assign RVALID_M0_o  = r_valid & ~grant;
    assign RVALID_M1_o  = r_valid & grant;
    assign RLAST_M0_o   = r_last & ~grant;
    assign RLAST_M1_o   = r_last & grant;
    assign RID_M0_o     = r_id;
    assign RID_M1_o     = r_id;
    assign RDATA_M0_o   = r_data;
    assign RDATA_M1_o   = r_data;
    assign RRESP_M0_o   = r_resp;
    assign RRESP_M1_o   = r_resp;

    assign ARID_S_o     = ar_id;
    assign ARADDR_S_o   = ar_addr;
    assign ARLEN_S_o    = ar_len;
    assign ARSIZE_S_o   = ar_size;
    assign ARBURST_S_o  = ar_burst;
    assign ARVALID_S_o  = (state == ST_ADDR) ? (6'b000001 << target) : 6'b000000;
    assign RREADY_S_o   = (state == ST_DATA && m_rready) ? (6'b000001 << target) : 6'b000000;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: randomized masters and slaves,
// checked against a transaction-level model (range-table decode,
// round-robin grant order, expected beat stream per transaction).
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int ID_W = 4, IDS_W = 8, ADDR_W = 32, DATA_W = 32, LEN_W = 4, SIZE_W = 3;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [ID_W-1:0]     ARID_M0_i, ARID_M1_i;
    logic [ADDR_W-1:0]   ARADDR_M0_i, ARADDR_M1_i;
    logic [LEN_W-1:0]    ARLEN_M0_i, ARLEN_M1_i;
    logic [SIZE_W-1:0]   ARSIZE_M0_i, ARSIZE_M1_i;
    logic [1:0]          ARBURST_M0_i, ARBURST_M1_i;
    logic                ARVALID_M0_i, ARVALID_M1_i;
    logic                ARREADY_M0_o, ARREADY_M1_o;
    logic [ID_W-1:0]     RID_M0_o, RID_M1_o;
    logic [DATA_W-1:0]   RDATA_M0_o, RDATA_M1_o;
    logic [1:0]          RRESP_M0_o, RRESP_M1_o;
    logic                RLAST_M0_o, RLAST_M1_o;
    logic                RVALID_M0_o, RVALID_M1_o;
    logic                RREADY_M0_i, RREADY_M1_i;
    logic [IDS_W-1:0]    ARID_S_o;
    logic [ADDR_W-1:0]   ARADDR_S_o;
    logic [LEN_W-1:0]    ARLEN_S_o;
    logic [SIZE_W-1:0]   ARSIZE_S_o;
    logic [1:0]          ARBURST_S_o;
    logic [5:0]          ARVALID_S_o;
    logic [5:0]          ARREADY_S_i;
    logic [6*IDS_W-1:0]  RID_S_i;
    logic [6*DATA_W-1:0] RDATA_S_i;
    logic [11:0]         RRESP_S_i;
    logic [5:0]          RLAST_S_i;
    logic [5:0]          RVALID_S_i;
    logic [5:0]          RREADY_S_o;

    axi_rd_arbiter #(
        .ID_W(ID_W), .IDS_W(IDS_W), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .LEN_W(LEN_W), .SIZE_W(SIZE_W)
    ) dut (
        .AXI_CLK_i(clk_sys), .AXI_RST_i(rst_n),
        .ARID_M0_i(ARID_M0_i), .ARADDR_M0_i(ARADDR_M0_i), .ARLEN_M0_i(ARLEN_M0_i),
        .ARSIZE_M0_i(ARSIZE_M0_i), .ARBURST_M0_i(ARBURST_M0_i), .ARVALID_M0_i(ARVALID_M0_i),
        .ARREADY_M0_o(ARREADY_M0_o), .RID_M0_o(RID_M0_o), .RDATA_M0_o(RDATA_M0_o),
        .RRESP_M0_o(RRESP_M0_o), .RLAST_M0_o(RLAST_M0_o), .RVALID_M0_o(RVALID_M0_o),
        .RREADY_M0_i(RREADY_M0_i),
        .ARID_M1_i(ARID_M1_i), .ARADDR_M1_i(ARADDR_M1_i), .ARLEN_M1_i(ARLEN_M1_i),
        .ARSIZE_M1_i(ARSIZE_M1_i), .ARBURST_M1_i(ARBURST_M1_i), .ARVALID_M1_i(ARVALID_M1_i),
        .ARREADY_M1_o(ARREADY_M1_o), .RID_M1_o(RID_M1_o), .RDATA_M1_o(RDATA_M1_o),
        .RRESP_M1_o(RRESP_M1_o), .RLAST_M1_o(RLAST_M1_o), .RVALID_M1_o(RVALID_M1_o),
        .RREADY_M1_i(RREADY_M1_i),
        .ARID_S_o(ARID_S_o), .ARADDR_S_o(ARADDR_S_o), .ARLEN_S_o(ARLEN_S_o),
        .ARSIZE_S_o(ARSIZE_S_o), .ARBURST_S_o(ARBURST_S_o), .ARVALID_S_o(ARVALID_S_o),
        .ARREADY_S_i(ARREADY_S_i), .RID_S_i(RID_S_i), .RDATA_S_i(RDATA_S_i),
        .RRESP_S_i(RRESP_S_i), .RLAST_S_i(RLAST_S_i), .RVALID_S_i(RVALID_S_i),
        .RREADY_S_o(RREADY_S_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Address map as an inclusive range table.
    logic [31:0] lo_t [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000,
                              32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
    logic [31:0] hi_t [6] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF,
                              32'h1000_03FF, 32'h1001_03FF, 32'h201F_FFFF};
    logic [31:0] edge_t [8] = '{32'h0000_3FFF, 32'h0000_4000, 32'h201F_FFFF, 32'h2020_0000,
                                32'h0000_FFFF, 32'h0003_0000, 32'h1000_0400, 32'h1001_03FF};

    function automatic int ref_slave(input logic [31:0] a);
        for (int n = 0; n < 6; n++)
            if (a >= lo_t[n] && a <= hi_t[n]) return n;
        return -1;
    endfunction

    function automatic logic [31:0] beat_data(input int s, input logic [7:0] id, input int k);
        return 32'hA500_0000 | (32'(s) << 20) | (32'(id) << 8) | 32'(k);
    endfunction

    function automatic logic [1:0] slave_resp(input int s);
        return (s % 2 == 1) ? 2'b01 : 2'b00;
    endfunction

    // Pending master requests and model state shared across runs.
    logic        pend [2];
    logic [31:0] q_addr [2];
    logic [3:0]  q_len [2];
    logic [3:0]  q_id [2];
    logic [2:0]  q_size [2];
    logic [1:0]  q_burst [2];
    int          last_g      = 1;
    bit          toggle_rr   = 0;
    int          rst_at_beat = -1;
    int          first_grant = -1;

    task automatic req(input int m, input logic [31:0] a, input int l, input int id);
        pend[m]    = 1'b1;
        q_addr[m]  = a;
        q_len[m]   = 4'(l);
        q_id[m]    = 4'(id);
        q_size[m]  = 3'($urandom_range(0, 2));
        q_burst[m] = 2'($urandom_range(0, 2));
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_n        = 1'b0;
        ARVALID_M0_i = 1'b0;
        ARVALID_M1_i = 1'b0;
        pend[0]      = 1'b0;
        pend[1]      = 1'b0;
        last_g       = 1;
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    // Cycle loop: drive masters/slaves after posedge, check on negedge.
    task automatic run(input int budget);
        bit          flight = 0, ar_done = 0, sv = 0;
        int          g = 0, tgt = -1, beat = 0, len = 0, cyc = 0;
        logic [7:0]  sid = 8'h0;
        logic        rr_g;
        logic [31:0] got_data;
        first_grant = -1;
        while ((pend[0] || pend[1] || flight) && cyc < budget) begin
            @(posedge clk_sys);
            #1;
            ARVALID_M0_i = pend[0]; ARADDR_M0_i = q_addr[0]; ARLEN_M0_i = q_len[0];
            ARID_M0_i = q_id[0]; ARSIZE_M0_i = q_size[0]; ARBURST_M0_i = q_burst[0];
            ARVALID_M1_i = pend[1]; ARADDR_M1_i = q_addr[1]; ARLEN_M1_i = q_len[1];
            ARID_M1_i = q_id[1]; ARSIZE_M1_i = q_size[1]; ARBURST_M1_i = q_burst[1];
            RREADY_M0_i = toggle_rr ? 1'(cyc & 1) : ($urandom_range(0, 3) != 0);
            RREADY_M1_i = toggle_rr ? 1'(cyc & 1) : ($urandom_range(0, 3) != 0);
            ARREADY_S_i = 6'($urandom);
            RVALID_S_i  = 6'($urandom);
            RLAST_S_i   = 6'($urandom);
            RRESP_S_i   = 12'($urandom);
            RID_S_i     = 48'({$urandom, $urandom});
            for (int n = 0; n < 6; n++) RDATA_S_i[n*DATA_W +: DATA_W] = $urandom;
            if (flight && tgt >= 0) begin
                if (!ar_done) begin
                    RVALID_S_i[tgt] = 1'b0;
                end else begin
                    if (!sv) sv = ($urandom_range(0, 3) != 0) || (rst_at_beat == beat);
                    RVALID_S_i[tgt]                 = sv;
                    RDATA_S_i[tgt*DATA_W +: DATA_W] = beat_data(tgt, sid, beat);
                    RID_S_i[tgt*IDS_W +: IDS_W]     = sid;
                    RRESP_S_i[tgt*2 +: 2]           = slave_resp(tgt);
                    RLAST_S_i[tgt]                  = (beat == len);
                end
            end
            if (rst_at_beat >= 0 && flight && tgt >= 0 && ar_done && sv && beat == rst_at_beat) begin
                check_eq("pre_rst_rvalid", g ? RVALID_M1_o : RVALID_M0_o, 1);
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst_arready", {ARREADY_M0_o, ARREADY_M1_o}, 0);
                check_eq("rst_rvalid", {RVALID_M0_o, RVALID_M1_o}, 0);
                check_eq("rst_rlast", {RLAST_M0_o, RLAST_M1_o}, 0);
                check_eq("rst_arvalid_s", ARVALID_S_o, 0);
                check_eq("rst_rready_s", RREADY_S_o, 0);
                rst_at_beat = -1;
                flight      = 0;
                break;
            end
            @(negedge clk_sys);
            if (!flight) begin
                int exp_g;
                exp_g = -1;
                if (pend[0] && pend[1]) exp_g = 1 - last_g;
                else if (pend[0])       exp_g = 0;
                else if (pend[1])       exp_g = 1;
                check_eq("arready_m0", ARREADY_M0_o, exp_g == 0);
                check_eq("arready_m1", ARREADY_M1_o, exp_g == 1);
                check_eq("idle_rvalid", {RVALID_M0_o, RVALID_M1_o}, 0);
                check_eq("idle_arvalid_s", ARVALID_S_o, 0);
                if (exp_g >= 0) begin
                    g       = exp_g;
                    last_g  = g;
                    pend[g] = 1'b0;
                    flight  = 1;
                    ar_done = 0;
                    sv      = 0;
                    beat    = 0;
                    tgt     = ref_slave(q_addr[g]);
                    len     = int'(q_len[g]);
                    sid     = {4'(g), q_id[g]};
                    if (first_grant < 0) first_grant = g;
                end
            end else begin
                rr_g     = g ? RREADY_M1_i : RREADY_M0_i;
                got_data = g ? RDATA_M1_o : RDATA_M0_o;
                check_eq("busy_arready", {ARREADY_M0_o, ARREADY_M1_o}, 0);
                check_eq("other_rvalid_rlast", g ? {RVALID_M0_o, RLAST_M0_o} : {RVALID_M1_o, RLAST_M1_o}, 0);
                if (tgt < 0) begin
                    check_eq("def_arvalid_s", ARVALID_S_o, 0);
                    check_eq("def_rready_s", RREADY_S_o, 0);
                    check_eq("def_rvalid", g ? RVALID_M1_o : RVALID_M0_o, 1);
                    if (rr_g) begin
                        check_eq("def_rdata", got_data, 0);
                        check_eq("def_rresp", g ? RRESP_M1_o : RRESP_M0_o, 2'b11);
                        check_eq("def_rid", g ? RID_M1_o : RID_M0_o, q_id[g]);
                        check_eq("def_rlast", g ? RLAST_M1_o : RLAST_M0_o, beat == len);
                        beat++;
                        if (beat > len) flight = 0;
                    end
                end else if (!ar_done) begin
                    check_eq("arvalid_s", ARVALID_S_o, 6'b000001 << tgt);
                    check_eq("arid_s", ARID_S_o, sid);
                    check_eq("araddr_s", ARADDR_S_o, q_addr[g]);
                    check_eq("arlen_s", ARLEN_S_o, q_len[g]);
                    check_eq("arsize_burst_s", {ARSIZE_S_o, ARBURST_S_o}, {q_size[g], q_burst[g]});
                    check_eq("addr_rvalid", {RVALID_M0_o, RVALID_M1_o}, 0);
                    if (ARREADY_S_i[tgt]) ar_done = 1;
                end else begin
                    check_eq("data_arvalid_s", ARVALID_S_o, 0);
                    check_eq("rready_s", RREADY_S_o, rr_g ? (6'b000001 << tgt) : 6'b000000);
                    check_eq("rvalid", g ? RVALID_M1_o : RVALID_M0_o, sv);
                    if (sv && rr_g) begin
                        check_eq("rdata", got_data, beat_data(tgt, sid, beat));
                        check_eq("rid", g ? RID_M1_o : RID_M0_o, q_id[g]);
                        check_eq("rresp", g ? RRESP_M1_o : RRESP_M0_o, slave_resp(tgt));
                        check_eq("rlast", g ? RLAST_M1_o : RLAST_M0_o, beat == len);
                        beat++;
                        sv = 0;
                        if (beat > len) flight = 0;
                    end
                end
            end
            cyc++;
        end
        check_eq("run_done", {pend[0], pend[1], flight}, 0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r < 6) return lo_t[r] + ($urandom % (hi_t[r] - lo_t[r] + 32'd1));
        if (r == 6) return edge_t[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pend[0] = 0; pend[1] = 0;
        for (int m = 0; m < 2; m++) begin
            q_addr[m] = 0; q_len[m] = 0; q_id[m] = 0; q_size[m] = 0; q_burst[m] = 0;
        end
        ARID_M0_i = 0; ARADDR_M0_i = 0; ARLEN_M0_i = 0; ARSIZE_M0_i = 0; ARBURST_M0_i = 0;
        ARID_M1_i = 0; ARADDR_M1_i = 0; ARLEN_M1_i = 0; ARSIZE_M1_i = 0; ARBURST_M1_i = 0;
        RREADY_M0_i = 1; RREADY_M1_i = 1;
        ARREADY_S_i = '1; RID_S_i = '0; RDATA_S_i = '0; RRESP_S_i = '0;
        RLAST_S_i = '1; RVALID_S_i = '1;
        ARVALID_M0_i = 1; ARVALID_M1_i = 1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_eq("rst_arready_m", {ARREADY_M0_o, ARREADY_M1_o}, 0);
        check_eq("rst_rvalid_m", {RVALID_M0_o, RVALID_M1_o}, 0);
        check_eq("rst_rlast_m", {RLAST_M0_o, RLAST_M1_o}, 0);
        check_eq("rst_arvalid_s0", ARVALID_S_o, 0);
        check_eq("rst_rready_s0", RREADY_S_o, 0);
        check_eq("rst_payload", {ARID_S_o, ARADDR_S_o, ARLEN_S_o}, 0);
        ARVALID_M0_i = 0; ARVALID_M1_i = 0;
        rst_n = 1'b1;

        req(0, 32'h0001_0004, 0, 3);
        run(200);

        do_reset();
        req(0, 32'h0002_0100, 1, 5);
        req(1, 32'h2000_0040, 2, 9);
        run(300);
        check_eq("tie_first_grant", first_grant, 0);

        req(1, 32'h3000_0000, 3, 6);
        run(200);

        toggle_rr = 1;
        req(1, 32'h2000_1000, 7, 10);
        run(300);
        toggle_rr = 0;

        for (int i = 0; i < 4; i++) begin
            req(int'($urandom_range(0, 1)), edge_t[i], int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            run(200);
        end

        do_reset();
        req(0, 32'h0001_0200, 5, 2);
        rst_at_beat = 2;
        run(300);
        do_reset();
        req(0, 32'h1000_0010, 1, 4);
        req(1, 32'h1001_0020, 1, 7);
        run(300);
        check_eq("post_rst_tie_grant", first_grant, 0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            if (sel[0]) req(0, pick_addr(), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if (sel[1]) req(1, pick_addr(), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            run(600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel interconnect core for the AXI bridge. It arbitrates AR requests from masters M0 (instruction fetch) and M1 (data) with round-robin fairness and decodes each request to one of six slaves S0–S5, or to an internal default slave on a decode miss. It then routes the R beats back to the granted master. Only one read transaction is in flight at a time. The AW/W/B path is a separate block.

## Interface
- ID_W, 4, master-side ID width (AXI_ID_BITS)
- IDS_W, 8, slave-side ID width (AXI_IDS_BITS) = {4-bit master tag, ID_W}
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 4, burst length width
- SIZE_W, 3, burst size width
- AXI_CLK_i  in  1  single clock; all state on rising edge
- AXI_RST_i  in  1  asynchronous, active-low reset
- ARID_M{0,1}_i  in  ID_W  master read ID
- ARADDR_M{0,1}_i / ARLEN_M{0,1}_i / ARSIZE_M{0,1}_i / ARBURST_M{0,1}_i  in  ADDR_W/LEN_W/SIZE_W/2  AR payload
- ARVALID_M{0,1}_i  in  1  AR request
- ARREADY_M{0,1}_o  out  1  AR accept
- RID_M{0,1}_o / RDATA_M{0,1}_o / RRESP_M{0,1}_o / RLAST_M{0,1}_o  out  ID_W/DATA_W/2/1  R payload
- RVALID_M{0,1}_o  out  1  R beat valid
- RREADY_M{0,1}_i  in  1  R beat accept
- ARID_S_o / ARADDR_S_o / ARLEN_S_o / ARSIZE_S_o / ARBURST_S_o  out  IDS_W/ADDR_W/LEN_W/SIZE_W/2  registered AR payload, broadcast to all slaves
- ARVALID_S_o  out  6  one-hot AR valid, bit n = Sn
- ARREADY_S_i  in  6  per-slave AR ready
- RID_S_i / RDATA_S_i / RRESP_S_i  in  6·IDS_W / 6·DATA_W / 6·2  packed per-slave R payload, slice n = Sn
- RLAST_S_i / RVALID_S_i  in  6 / 6  per-slave R last and valid
- RREADY_S_o  out  6  one-hot R ready

## Operation
- Address map, inclusive ranges; anything else is a miss:
  - S0 0x0000_0000–0x0000_3FFF
  - S1 0x0001_0000–0x0001_FFFF
  - S2 0x0002_0000–0x0002_FFFF
  - S3 0x1000_0000–0x1000_03FF
  - S4 0x1001_0000–0x1001_03FF
  - S5 0x2000_0000–0x201F_FFFF
- FSM states: IDLE, ADDR, DATA, DEF.
- IDLE, arbitration:
  - Only one master valid: that master is granted.
  - Both valid: grant the master not granted last. The last-grant register resets to M1, so M0 wins the first tie.
  - Grant cycle: ARREADY_Mg=1 combinationally. The payload, the decoded target, and ARID_S = {4'(g), ARID_Mg} are registered.
  - Next state: ADDR on a hit, DEF on a miss.
- ADDR: ARVALID_S_o[t]=1 with stable payload until ARREADY_S_i[t]=1, then go to DATA.
- DATA, combinational routing:
  - Slave t to master g: RVALID, RDATA, RRESP, RLAST, and RID = RID_S[ID_W-1:0].
  - RREADY_S_o[t] = RREADY_Mg.
  - Return to IDLE on the handshake where RLAST is set.
- DEF: internal default slave produces ARLEN+1 beats to master g.
  - Each beat: RVALID=1, RDATA=0, RRESP=2'b11 (DECERR), RID = captured ID.
  - Beat counter (LEN_W bits) increments per handshake. RLAST=1 when counter == ARLEN.
  - Return to IDLE after the last handshake.
- Non-granted master and non-targeted slaves see all valid/ready outputs at 0. Payload outputs are don't-care but driven.

## Timing
- Reset (async assert, sync release): state=IDLE, last-grant=M1, counter=0, all payload registers=0. All ARREADY_M, RVALID_M, RLAST_M, ARVALID_S, and RREADY_S outputs are 0.
- AR latency: master handshake in cycle N → ARVALID_S_o in cycle N+1.
- R path: zero added latency (combinational). Back-pressure from RREADY holds RVALID and RDATA.
- ARREADY_M is never asserted outside IDLE. A new request is accepted no earlier than the cycle after the RLAST handshake.
- DEF: first beat is valid in the cycle after the grant. A 1-beat burst (ARLEN=0) asserts RLAST on that first beat.
- Reset asserted mid-burst: immediately returns to IDLE and drops all valids. The slave-side burst is abandoned.

## Test plan
- M0 reads 0x0001_0004 with ARLEN=0 and ARID=3:
  - ARVALID_S_o=6'b000010 one cycle later, ARID_S=0x03.
  - RID_M0=3 and RLAST are returned. M1 outputs stay 0.
- M0 and M1 both valid in the same cycle after reset, to S2 and S5:
  - M0 is granted first.
  - M1 is granted in the first IDLE after M0's RLAST, with ARID_S upper nibble = 1.
- M1 reads 0x3000_0000 with ARLEN=3:
  - Four DEF beats: RRESP=2'b11, RDATA=0, RLAST only on the 4th.
  - No ARVALID_S_o bit set.
- S5 burst of ARLEN=7 with RREADY_M1 toggling every other cycle:
  - All 8 beats are delivered in order with no loss.
  - RREADY_S_o[5] mirrors RREADY_M1.
- Boundaries:
  - 0x0000_3FFF goes to S0.
  - 0x0000_4000 goes to DEF.
  - 0x201F_FFFF goes to S5.
  - 0x2020_0000 goes to DEF.
- Async reset driven low during the 3rd beat of an S1 burst:
  - All outputs go to 0 within the same cycle.
  - After release, a tie grants M0.
